// File: rtl/glyph_renderer.sv
// rtl/glyph_renderer.sv - hex glyph (0-F) renderer feeding a framebuffer write stream
module glyph_renderer #(
    parameter int FB_COLS = 100,
    parameter int FB_ROWS = 75
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_row,
    input  logic [6:0]  cmd_col,
    input  logic [3:0]  cmd_glyph,
    input  logic [7:0]  cmd_fg,
    input  logic [7:0]  cmd_bg,
    input  logic        cmd_transp,
    output logic        fb_wr_en,
    output logic [13:0] fb_wr_addr,
    output logic [7:0]  fb_wr_data,
    input  logic        fb_wr_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    localparam logic [7:0] COL_LIM = 8'(FB_COLS);
    localparam logic [7:0] ROW_LIM = 8'(FB_ROWS);

    state_t      state_q, state_d;
    logic [1:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic [6:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [3:0]  glyph_q, glyph_d;
    logic [7:0]  fg_q, fg_d;
    logic [7:0]  bg_q, bg_d;
    logic        transp_q, transp_d;
    logic        wr_en_q, wr_en_d;
    logic [13:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Cell evaluation inputs: the command ports on acceptance, latched fields afterwards.
    logic [6:0]  ev_row, ev_col;
    logic [3:0]  ev_glyph;
    logic [7:0]  ev_fg, ev_bg;
    logic        ev_transp;
    logic [1:0]  ev_x;
    logic [2:0]  ev_y;
    logic        load;
    logic [7:0]  row_sum, col_sum;
    logic [2:0]  font_bits;
    logic        pix_on, clip, ev_write;
    logic [7:0]  ev_colour;

    // 3x5 font, row r of glyph g, MSB is the leftmost column.
    function automatic logic [2:0] font_row(input logic [3:0] g, input logic [2:0] r);
        logic [14:0] f;
        case (g)
            4'h0: f = {3'd7, 3'd5, 3'd5, 3'd5, 3'd7};
            4'h1: f = {3'd2, 3'd6, 3'd2, 3'd2, 3'd7};
            4'h2: f = {3'd7, 3'd1, 3'd7, 3'd4, 3'd7};
            4'h3: f = {3'd7, 3'd1, 3'd7, 3'd1, 3'd7};
            4'h4: f = {3'd5, 3'd5, 3'd7, 3'd1, 3'd1};
            4'h5: f = {3'd7, 3'd4, 3'd7, 3'd1, 3'd7};
            4'h6: f = {3'd7, 3'd4, 3'd7, 3'd5, 3'd7};
            4'h7: f = {3'd7, 3'd1, 3'd1, 3'd1, 3'd1};
            4'h8: f = {3'd7, 3'd5, 3'd7, 3'd5, 3'd7};
            4'h9: f = {3'd7, 3'd5, 3'd7, 3'd1, 3'd7};
            4'hA: f = {3'd7, 3'd5, 3'd7, 3'd5, 3'd5};
            4'hB: f = {3'd6, 3'd5, 3'd6, 3'd5, 3'd6};
            4'hC: f = {3'd7, 3'd4, 3'd4, 3'd4, 3'd7};
            4'hD: f = {3'd6, 3'd5, 3'd5, 3'd5, 3'd6};
            4'hE: f = {3'd7, 3'd4, 3'd7, 3'd4, 3'd7};
            default: f = {3'd7, 3'd4, 3'd7, 3'd4, 3'd4};
        endcase
        case (r)
            3'd0:    return f[14:12];
            3'd1:    return f[11:9];
            3'd2:    return f[8:6];
            3'd3:    return f[5:3];
            3'd4:    return f[2:0];
            default: return 3'd0;
        endcase
    endfunction

    // Registered state, command fields and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            glyph_q   <= '0;
            fg_q      <= '0;
            bg_q      <= '0;
            transp_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_q     <= row_d;
            col_q     <= col_d;
            glyph_q   <= glyph_d;
            fg_q      <= fg_d;
            bg_q      <= bg_d;
            transp_q  <= transp_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: step sequencing, then evaluation of the cell to present next.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        row_d     = row_q;
        col_d     = col_q;
        glyph_d   = glyph_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        transp_d  = transp_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ready_d   = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        ev_row    = row_q;
        ev_col    = col_q;
        ev_glyph  = glyph_q;
        ev_fg     = fg_q;
        ev_bg     = bg_q;
        ev_transp = transp_q;
        ev_x      = x_q;
        ev_y      = y_q;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    row_d     = cmd_row;
                    col_d     = cmd_col;
                    glyph_d   = cmd_glyph;
                    fg_d      = cmd_fg;
                    bg_d      = cmd_bg;
                    transp_d  = cmd_transp;
                    x_d       = 2'd0;
                    y_d       = 3'd0;
                    ev_row    = cmd_row;
                    ev_col    = cmd_col;
                    ev_glyph  = cmd_glyph;
                    ev_fg     = cmd_fg;
                    ev_bg     = cmd_bg;
                    ev_transp = cmd_transp;
                    ev_x      = 2'd0;
                    ev_y      = 3'd0;
                    load      = 1'b1;
                    state_d   = S_DRAW;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DRAW: begin
                if (wr_en_q && !fb_wr_ready) begin
                    // Stalled write: hold request, address and data.
                    wr_en_d = 1'b1;
                end else if (x_q == 2'd3 && y_q == 3'd5) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (x_q == 2'd3) begin
                        x_d = 2'd0;
                        y_d = y_q + 3'd1;
                    end else begin
                        x_d = x_q + 2'd1;
                    end
                    ev_x = x_d;
                    ev_y = y_d;
                    load = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // 8-bit sums so that a 7-bit overflow lands in the clipped range.
        row_sum   = {1'b0, ev_row} + {5'd0, ev_y};
        col_sum   = {1'b0, ev_col} + {6'd0, ev_x};
        font_bits = font_row(ev_glyph, ev_y);
        case (ev_x)
            2'd0:    pix_on = font_bits[2];
            2'd1:    pix_on = font_bits[1];
            2'd2:    pix_on = font_bits[0];
            default: pix_on = 1'b0;
        endcase
        clip      = (col_sum >= COL_LIM) || (row_sum >= ROW_LIM);
        ev_colour = pix_on ? ev_fg : ev_bg;
        ev_write  = !clip && !(ev_transp && !pix_on);

        if (load) begin
            wr_en_d   = ev_write;
            wr_addr_d = {row_sum[6:0], col_sum[6:0]};
            wr_data_d = ev_colour;
        end
    end

    assign cmd_ready  = ready_q;
    assign fb_wr_en   = wr_en_q;
    assign fb_wr_addr = wr_addr_q;
    assign fb_wr_data = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
